// File: rtl/traffic_fsm.sv
// Main/side-road traffic-light controller with optional pedestrian walk phase.
// Define TRAFFIC_WALK_EN to build the WALK state, walk-pending latch and Walk_Light.
module traffic_fsm #(
  parameter int unsigned TICK_DIV   = 1000,
  parameter int unsigned CNT_W      = 4,
  parameter int unsigned T_BASE_DEF = 6,
  parameter int unsigned T_EXT_DEF  = 3,
  parameter int unsigned T_YEL_DEF  = 2
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             Reset_Sync,
  input  logic             Sensor_Sync,
  input  logic             WR_Sync,
  input  logic             Prog_Sync,
  input  logic [1:0]       Time_Param_Sel,
  input  logic [CNT_W-1:0] Time_Value,
  output logic [2:0]       Main_Light,
  output logic [2:0]       Side_Light,
  output logic             Walk_Light,
  output logic [2:0]       State
);

  typedef enum logic [2:0] {
    MG     = 3'd0,
    MG_EXT = 3'd1,
    MY     = 3'd2,
    WALK   = 3'd3,
    SG     = 3'd4,
    SG_EXT = 3'd5,
    SY     = 3'd6
  } state_t;

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_G = 3'b001;

  state_t           state_q, state_d;
  logic [PW-1:0]    presc_q;
  logic [CNT_W-1:0] cnt_q, cnt_eff;
  logic             armed_q;
  logic             sensor_q;
  logic             walk_pend;
  logic [CNT_W-1:0] t_base_q, t_ext_q, t_yel_q;
  logic [2:0]       main_q, side_q, main_d, side_d;
  logic             walk_d;
  logic             tick, expire;

  function automatic logic [CNT_W-1:0] interval(input state_t s);
    case (s)
      MG, SG:               interval = t_base_q;
      MG_EXT, SG_EXT, WALK: interval = t_ext_q;
      default:              interval = t_yel_q;
    endcase
  endfunction

  // After reset/reprogram the counter is not yet loaded; the first MG cycle
  // behaves as a fresh entry so the full base interval is still served.
  assign cnt_eff = armed_q ? cnt_q : (t_base_q - CNT_W'(1));
  assign tick    = (presc_q == PRESC_MAX);
  assign expire  = tick && (cnt_eff == '0);

`ifdef TRAFFIC_WALK_EN
  logic walk_q;
  logic walk_lamp_q;

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      walk_q      <= 1'b0;
      walk_lamp_q <= 1'b0;
    end else if (Reset_Sync || Prog_Sync) begin
      walk_q      <= 1'b0;
      walk_lamp_q <= 1'b0;
    end else begin
      if (state_d == WALK && state_q != WALK) walk_q <= 1'b0;
      else if (state_q != WALK && WR_Sync)    walk_q <= 1'b1;
      walk_lamp_q <= walk_d;
    end
  end

  assign walk_pend  = walk_q | WR_Sync;
  assign Walk_Light = walk_lamp_q;
`else
  logic unused_wr;
  assign unused_wr  = WR_Sync;
  assign walk_pend  = 1'b0;
  assign Walk_Light = 1'b0;
`endif

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state_q  <= MG;
      presc_q  <= '0;
      cnt_q    <= '0;
      armed_q  <= 1'b0;
      sensor_q <= 1'b0;
      t_base_q <= CNT_W'(T_BASE_DEF);
      t_ext_q  <= CNT_W'(T_EXT_DEF);
      t_yel_q  <= CNT_W'(T_YEL_DEF);
      main_q   <= LAMP_G;
      side_q   <= LAMP_R;
    end else if (Reset_Sync) begin
      state_q  <= MG;
      presc_q  <= '0;
      cnt_q    <= '0;
      armed_q  <= 1'b0;
      sensor_q <= 1'b0;
      t_base_q <= CNT_W'(T_BASE_DEF);
      t_ext_q  <= CNT_W'(T_EXT_DEF);
      t_yel_q  <= CNT_W'(T_YEL_DEF);
      main_q   <= LAMP_G;
      side_q   <= LAMP_R;
    end else if (Prog_Sync) begin
      if (Time_Value != '0) begin
        case (Time_Param_Sel)
          2'd0:    t_base_q <= Time_Value;
          2'd1:    t_ext_q  <= Time_Value;
          2'd2:    t_yel_q  <= Time_Value;
          default: ;
        endcase
      end
      state_q  <= MG;
      presc_q  <= '0;
      cnt_q    <= '0;
      armed_q  <= 1'b0;
      sensor_q <= 1'b0;
      main_q   <= LAMP_G;
      side_q   <= LAMP_R;
    end else begin
      state_q <= state_d;
      armed_q <= 1'b1;
      if (expire) begin
        presc_q <= '0;
        cnt_q   <= interval(state_d) - CNT_W'(1);
      end else if (tick) begin
        presc_q <= '0;
        cnt_q   <= cnt_eff - CNT_W'(1);
      end else begin
        presc_q <= presc_q + PW'(1);
        cnt_q   <= cnt_eff;
      end
      if (state_q == MG && expire)           sensor_q <= 1'b0;
      else if (state_q == MG && Sensor_Sync) sensor_q <= 1'b1;
      main_q <= main_d;
      side_q <= side_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (expire) begin
      case (state_q)
        MG:      state_d = (sensor_q || Sensor_Sync) ? MG_EXT : MY;
        MG_EXT:  state_d = MY;
        MY:      state_d = walk_pend ? WALK : SG;
        WALK:    state_d = SG;
        SG:      state_d = Sensor_Sync ? SG_EXT : SY;
        SG_EXT:  state_d = SY;
        SY:      state_d = MG;
        default: state_d = MG;
      endcase
    end
  end

  always_comb begin
    main_d = LAMP_G;
    side_d = LAMP_R;
    walk_d = 1'b0;
    case (state_d)
      MG, MG_EXT: begin main_d = LAMP_G; side_d = LAMP_R; end
      MY:         begin main_d = LAMP_Y; side_d = LAMP_R; end
      WALK:       begin main_d = LAMP_R; side_d = LAMP_R; walk_d = 1'b1; end
      SG, SG_EXT: begin main_d = LAMP_R; side_d = LAMP_G; end
      SY:         begin main_d = LAMP_R; side_d = LAMP_Y; end
      default:    begin main_d = LAMP_G; side_d = LAMP_R; end
    endcase
  end

  assign Main_Light = main_q;
  assign Side_Light = side_q;
  assign State      = state_q;

endmodule

// File: doc/traffic_fsm.md
# traffic_fsm

- Main-road/side-road traffic-light controller with a pedestrian walk phase.
- Sits directly downstream of the input synchronizer and consumes its already-synchronized `Sensor_Sync`, `WR_Sync`, `Prog_Sync` and `Reset_Sync` outputs.
- Drives registered lamp outputs from a 7-state FSM timed by an internal prescaler and a down-counting interval timer.
- The base, extended and yellow intervals are reprogrammable at run time.

## Interface
- `TICK_DIV`, 1000: clk cycles per timer tick (one "second"); ≥1.
- `CNT_W`, 4: interval register/counter width; intervals 1..2^CNT_W−1 ticks.
- `T_BASE_DEF`, 6: reset value of base interval (ticks).
- `T_EXT_DEF`, 3: reset value of extended interval (ticks).
- `T_YEL_DEF`, 2: reset value of yellow interval (ticks).
- `clk` in 1: single clock, rising edge.
- `Reset` in 1: asynchronous, active-low; 0 resets all state immediately.
- `Reset_Sync` in 1: synchronous, active-high soft reset from the synchronizer.
- `Sensor_Sync` in 1: side-road vehicle present (level).
- `WR_Sync` in 1: walk request (level or pulse).
- `Prog_Sync` in 1: reprogram strobe (level).
- `Time_Param_Sel` in 2: 0 base, 1 extended, 2 yellow, 3 none.
- `Time_Value` in CNT_W: value written on reprogram.
- `Main_Light` out 3: {R,Y,G}, one-hot.
- `Side_Light` out 3: {R,Y,G}, one-hot.
- `Walk_Light` out 1: pedestrian walk lamp.
- `State` out 3: current FSM state code (debug).

## Operation
- States/codes: MG=0, MG_EXT=1, MY=2, WALK=3, SG=4, SG_EXT=5, SY=6.
- Lamps per state:
  - MG, MG_EXT: main G / side R.
  - MY: main Y / side R.
  - WALK: both R, `Walk_Light`=1.
  - SG, SG_EXT: main R / side G.
  - SY: main R / side Y.
- State durations and transitions:
  - MG lasts T_BASE ticks; at expiry go to MG_EXT if the sensor latch is set, else MY.
  - MG_EXT lasts T_EXT ticks, then MY.
  - MY lasts T_YEL ticks; at expiry go to WALK if walk pending, else SG.
  - WALK lasts T_EXT ticks, then SG.
  - SG lasts T_BASE ticks; at expiry go to SG_EXT if `Sensor_Sync`=1 in that cycle, else SY.
  - SG_EXT lasts T_EXT ticks, then SY.
  - SY lasts T_YEL ticks, then MG.
- Sensor latch:
  - Set by `Sensor_Sync`=1 in any MG cycle.
  - Cleared on leaving MG.
  - The expiry cycle itself counts: the decision uses latch OR `Sensor_Sync`.
- Walk-pending latch:
  - Set by `WR_Sync`=1 in any state except WALK; `WR_Sync` during WALK is ignored.
  - Cleared on entering WALK.
  - A request in the MY expiry cycle is honoured in that same decision.
- Reprogram (each cycle `Prog_Sync`=1):
  - Writes `Time_Value` into the register selected by `Time_Param_Sel`.
  - A write with `Time_Value`=0 or sel=3 is dropped and the register is unchanged.
  - The FSM is forced to MG with the timer, prescaler and both latches cleared, and is held in MG while `Prog_Sync`=1.
  - The new value takes effect from the next state entry.
- Priority: `Reset` (async) > `Reset_Sync` > `Prog_Sync` > normal sequencing.
- `Reset_Sync`=1 behaves exactly like `Reset` but takes effect on the clock edge; interval registers return to their defaults.

## Timing
- Reset values:
  - State=MG(0), `Main_Light`=3'b001, `Side_Light`=3'b100, `Walk_Light`=0.
  - Intervals = *_DEF; latches, prescaler and counter = 0.
- All outputs are registered and change on the clk edge that enters the new state, with no glitches.
- Timer mechanics:
  - On state entry the prescaler restarts at 0 and the counter loads interval−1.
  - A tick fires when the prescaler reaches TICK_DIV−1.
  - The state exits on the tick where the counter = 0.
  - A state therefore lasts exactly N·TICK_DIV clk cycles, where N is its interval.
- Counter arithmetic is unsigned CNT_W bits and never wraps: the load is always ≥0 because intervals are ≥1.
- Release of `Prog_Sync` or `Reset_Sync` starts a full MG interval on the next cycle.
- Async `Reset` assertion mid-state drops lamps to reset values immediately. Release is sampled on the next rising edge.

## Configuration
- `TRAFFIC_WALK_EN` defined: WALK state, walk-pending latch and `Walk_Light` behave as above.
- Not defined: WALK state and latch are not built, `WR_Sync` is ignored, MY always goes to SG, and `Walk_Light` is tied to 0. The port list is unchanged.

## Test plan
- TICK_DIV=2, defaults, no inputs, release `Reset` → MG 12 cycles, MY 4, SG 12, SY 4, back to MG; state codes 0,2,4,6,0.
- `Sensor_Sync`=1 pulse mid-MG → MG 12 cycles, then MG_EXT 6 cycles (`Main_Light`=001), then MY. Holding `Sensor_Sync`=1 through SG expiry → SG_EXT 6 cycles.
- `WR_Sync` one-cycle pulse in SG → next MY goes to WALK for 6 cycles with `Walk_Light`=1 and both lights 100. A second pulse during WALK is ignored: the next MY goes to SG.
- `Prog_Sync`=1 one cycle with sel=2, value=5 during SG → immediate MG. The next MY lasts 10 cycles. Sel=0 with value=0 leaves base at 6.
- `Reset` low mid-SY → lamps 001/100 asynchronously before the next edge. `Reset_Sync`=1 mid-WALK → MG on the next edge and intervals restored to defaults.
- Compile without `TRAFFIC_WALK_EN` and repeat the walk scenario → `Walk_Light` stays 0 and MY goes to SG.
